// File: rtl/pipe_intr_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake, a 2-entry skid buffer,
// synchronous flush and interrupt tagging of the next accepted instruction.
module pipe_intr_skid_reg #(
   parameter int                 INST_W    = 32,
   parameter int                 PC_W      = 32,
   parameter int                 EXC_W     = 5,
   parameter logic [INST_W-1:0]  NOP_INST  = '0,
   parameter logic [EXC_W-1:0]   INTR_CODE = EXC_W'(1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [PC_W-1:0]   in_pc4,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic              flush,
   input  logic              intr_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc,
   output logic [PC_W-1:0]   out_pc4,
   output logic [EXC_W-1:0]  out_exc,
   output logic              intr_pend
);

   // tag marks an entry that consumed the pending interrupt, so a flush can re-pend it
   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   pc4;
      logic [EXC_W-1:0]  exc;
      logic              tag;
   } entry_t;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_ent;
   logic   main_vld, main_vld_d;
   logic   skid_vld, skid_vld_d;
   logic   pend_q, pend_d;
   logic   accept, drain, want_tag;

   assign in_ready = ~skid_vld;
   assign accept   = in_valid & in_ready;
   assign drain    = main_vld & out_ready;
   assign want_tag = pend_q | intr_req;

   always_comb begin
      in_ent      = '0;
      in_ent.inst = in_inst;
      in_ent.pc   = in_pc;
      in_ent.pc4  = in_pc4;
      in_ent.tag  = want_tag;
      if (want_tag)
         in_ent.exc = (in_exc != '0) ? in_exc : INTR_CODE;
      else
         in_ent.exc = in_exc;
   end

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld;
      skid_vld_d = skid_vld;
      pend_d     = pend_q;
      if (flush) begin
         // any interrupt riding on a dropped entry (or arriving now) stays pending
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
         pend_d     = pend_q | intr_req | (main_vld & main_q.tag) | (skid_vld & skid_q.tag);
      end else begin
         pend_d = accept ? 1'b0 : want_tag;
         if (!main_vld) begin
            if (accept) begin
               main_d     = in_ent;
               main_vld_d = 1'b1;
            end
         end else if (drain) begin
            if (skid_vld) begin
               main_d     = skid_q;
               skid_vld_d = 1'b0;
            end else if (accept) begin
               main_d = in_ent;
            end else begin
               main_vld_d = 1'b0;
            end
         end else if (accept) begin
            skid_d     = in_ent;
            skid_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_vld <= main_vld_d;
         skid_vld <= skid_vld_d;
         pend_q   <= pend_d;
      end
   end

   assign out_valid = main_vld;
   assign out_inst  = main_vld ? main_q.inst : NOP_INST;
   assign out_pc    = main_q.pc;
   assign out_pc4   = main_q.pc4;
   assign out_exc   = main_q.exc;
   assign intr_pend = pend_q;

endmodule

// File: tb/tb_pipe_intr_skid_reg.sv
// Scoreboard bench for pipe_intr_skid_reg: directed scenarios followed by a
// random handshake/flush/interrupt phase.
module tb_pipe_intr_skid_reg;
   localparam int             IW    = 32;
   localparam int             PW    = 32;
   localparam int             EW    = 5;
   localparam logic [IW-1:0]  NOP   = 32'h00000013;
   localparam logic [EW-1:0]  ICODE = 5'd1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, in_ready;
   logic [IW-1:0] in_inst = '0;
   logic [PW-1:0] in_pc = '0, in_pc4 = '0;
   logic [EW-1:0] in_exc = '0;
   logic          flush = 1'b0, intr_req = 1'b0;
   logic          out_valid, out_ready = 1'b0;
   logic [IW-1:0] out_inst;
   logic [PW-1:0] out_pc, out_pc4;
   logic [EW-1:0] out_exc;
   logic          intr_pend;

   pipe_intr_skid_reg #(.INST_W(IW), .PC_W(PW), .EXC_W(EW), .NOP_INST(NOP), .INTR_CODE(ICODE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .in_pc4(in_pc4), .in_exc(in_exc), .flush(flush), .intr_req(intr_req),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
      .out_pc4(out_pc4), .out_exc(out_exc), .intr_pend(intr_pend)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] pc;
      logic [EW-1:0] exc;
      logic          tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic tb_pend = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [IW-1:0] inst_of(input logic [PW-1:0] pc);
      return pc ^ 32'hC0DE_0000;
   endfunction

   // inputs are already stable; score this edge, advance, then check state
   task automatic tick();
      logic acc, drn, tag;
      exp_t e;
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (drn && !flush && sb.size() != 0) begin
         e = sb.pop_front();
         chk("out_pc", 64'(out_pc), 64'(e.pc));
         chk("out_pc4", 64'(out_pc4), 64'(e.pc + 32'd4));
         chk("out_inst", 64'(out_inst), 64'(inst_of(e.pc)));
         chk("out_exc", 64'(out_exc), 64'(e.exc));
      end
      if (flush) begin
         foreach (sb[i]) if (sb[i].tag) tb_pend = 1'b1;
         if (intr_req) tb_pend = 1'b1;
         sb.delete();
      end else if (acc) begin
         tag   = tb_pend | intr_req;
         e.pc  = in_pc;
         e.tag = tag;
         e.exc = tag ? ((in_exc != '0) ? in_exc : ICODE) : in_exc;
         sb.push_back(e);
         tb_pend = 1'b0;
      end else begin
         tb_pend = tb_pend | intr_req;
      end
      @(posedge clk);
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      chk("intr_pend", 64'(intr_pend), 64'(tb_pend));
      if (!out_valid) chk("nop_inst", 64'(out_inst), 64'(NOP));
   endtask

   task automatic drv(input logic v, input logic [PW-1:0] pc, input logic [EW-1:0] exc,
                      input logic ordy, input logic fl, input logic ir);
      in_valid  = v;
      in_pc     = pc;
      in_pc4    = pc + 32'd4;
      in_inst   = inst_of(pc);
      in_exc    = exc;
      out_ready = ordy;
      flush     = fl;
      intr_req  = ir;
      tick();
   endtask

   initial begin
      #1;
      chk("rst0_valid", 64'(out_valid), 64'd0);
      chk("rst0_ready", 64'(in_ready), 64'd1);
      chk("rst0_inst", 64'(out_inst), 64'(NOP));
      chk("rst0_pc", 64'(out_pc), 64'd0);
      chk("rst0_exc", 64'(out_exc), 64'd0);
      chk("rst0_pend", 64'(intr_pend), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // streaming: one per cycle, one cycle latency
      drv(1, 32'h100, 0, 1, 0, 0);
      chk("s_pc0", 64'(out_pc), 64'h100);
      drv(1, 32'h104, 0, 1, 0, 0);
      chk("s_pc1", 64'(out_pc), 64'h104);
      drv(1, 32'h108, 0, 1, 0, 0);
      chk("s_pc2", 64'(out_pc), 64'h108);
      drv(0, 0, 0, 1, 0, 0);

      // backpressure into the skid entry
      drv(1, 32'h200, 0, 0, 0, 0);
      drv(1, 32'h204, 0, 0, 0, 0);
      chk("bp_ready", 64'(in_ready), 64'd0);
      chk("bp_main", 64'(out_pc), 64'h200);
      drv(0, 0, 0, 1, 0, 0);
      chk("bp_skid", 64'(out_pc), 64'h204);
      chk("bp_ready1", 64'(in_ready), 64'd1);
      drv(1, 32'h208, 0, 1, 0, 0);
      chk("bp_next", 64'(out_pc), 64'h208);
      drv(0, 0, 0, 1, 0, 0);

      // flush with both entries full, then with an accept in the same cycle
      drv(1, 32'h300, 0, 0, 0, 0);
      drv(1, 32'h304, 0, 0, 0, 0);
      drv(1, 32'h308, 0, 0, 1, 0);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_inst", 64'(out_inst), 64'(NOP));
      drv(1, 32'h310, 0, 0, 0, 0);
      drv(1, 32'h314, 0, 0, 1, 0);
      chk("fl2_valid", 64'(out_valid), 64'd0);
      drv(1, 32'h30C, 0, 1, 0, 0);
      chk("fl_after", 64'(out_pc), 64'h30C);
      drv(0, 0, 0, 1, 0, 0);
      chk("fl_alone", 64'(out_valid), 64'd0);

      // interrupt tagging
      drv(0, 0, 0, 1, 0, 1);
      chk("ir_pend", 64'(intr_pend), 64'd1);
      drv(1, 32'h500, 0, 1, 0, 0);
      chk("ir_code", 64'(out_exc), 64'(ICODE));
      chk("ir_clr", 64'(intr_pend), 64'd0);
      drv(0, 0, 0, 1, 0, 1);
      drv(1, 32'h504, 5'd4, 1, 0, 0);
      chk("ir_keep", 64'(out_exc), 64'd4);
      drv(1, 32'h508, 0, 1, 0, 1);
      chk("ir_same", 64'(out_exc), 64'(ICODE));
      chk("ir_same_pend", 64'(intr_pend), 64'd0);
      drv(1, 32'h50C, 0, 1, 0, 0);
      chk("ir_untag", 64'(out_exc), 64'd0);
      drv(0, 0, 0, 1, 0, 0);

      // flush of a tagged entry re-pends the interrupt
      drv(0, 0, 0, 0, 0, 1);
      drv(1, 32'h600, 0, 0, 0, 0);
      chk("ft_tag", 64'(out_exc), 64'(ICODE));
      chk("ft_pend0", 64'(intr_pend), 64'd0);
      drv(0, 0, 0, 0, 1, 0);
      chk("ft_pend1", 64'(intr_pend), 64'd1);
      drv(1, 32'h604, 0, 1, 0, 0);
      chk("ft_code", 64'(out_exc), 64'(ICODE));
      drv(0, 0, 0, 1, 0, 0);

      // async reset mid-stream with both entries full and an interrupt pending
      drv(1, 32'h400, 0, 0, 0, 0);
      drv(1, 32'h404, 0, 0, 0, 0);
      drv(1, 32'h408, 0, 0, 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_inst", 64'(out_inst), 64'(NOP));
      chk("rst_pend", 64'(intr_pend), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      sb.delete();
      tb_pend  = 1'b0;
      in_valid = 1'b0;
      intr_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // random phase
      for (int i = 0; i < 400; i++) begin
         logic [EW-1:0] ex;
         ex = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(1, 31)) : '0;
         drv($urandom_range(0, 3) != 0, 32'h1000 + 32'(i * 4), ex,
             $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0);
      end
      for (int i = 0; i < 4; i++) drv(0, 0, 0, 1, 0, 0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
